axi_read_responder: RTL and testbench
=====================================

AXI_READ_RESPONDER -- requirements
Module: axi_read_responder

Interface
REQ-001 Parameter ADDR_W, default `PADDR_SIZE, AR address width.
REQ-002 Parameter DATA_W, default `XLEN, R data width (bytes per beat NB = DATA_W/8).
REQ-003 Parameter ID_W, default 4, AXI ID width.
REQ-004 clk  input  1  single clock; all logic on its rising edge.
REQ-005 rst  input  1  asynchronous, active-low reset (asserted when 0).
REQ-006 ar_valid  input  1  read address valid.
REQ-007 ar_ready  output  1  read address accepted when high with ar_valid.
REQ-008 ar_id  input  ID_W  burst ID.
REQ-009 ar_addr  input  ADDR_W  start byte address.
REQ-010 ar_len  input  8  beats minus one.
REQ-011 ar_size  input  3  log2 bytes per beat.
REQ-012 ar_burst  input  2  0 FIXED, 1 INCR, 2 WRAP, 3 reserved.
REQ-013 r_valid  output  1  read data valid.
REQ-014 r_ready  input  1  initiator ready (may be held high permanently).
REQ-015 r_id / r_data / r_resp / r_last  output  ID_W / DATA_W / 2 / 1  beat payload.
REQ-016 mem_ren / mem_raddr  output  1 / ADDR_W  backing SRAM read request, byte address aligned to NB.
REQ-017 mem_rdata  input  DATA_W  SRAM data, valid exactly one cycle after mem_ren.

Function
REQ-018 AR queue: 2 entries; ar_ready = queue not full; push on ar_valid & ar_ready; in-order service.
REQ-019 FSM IDLE/BURST: IDLE with queue non-empty pops head, loads addr/id/len/size/burst, clears beat counter, enters BURST next cycle.
REQ-020 BURST asserts mem_ren only when skid occupancy + reads in flight < 2; returns to IDLE the cycle after issuing beat len; back-to-back bursts lose at most one cycle.
REQ-021 Address step per issued beat: INCR addr + (1<<size); FIXED unchanged; WRAP stays within the aligned (len+1)<<size window, wrapping to its base.
REQ-022 Beat counter 8 bits; r_last = 1 exactly on beat index ar_len (len 0 -> single beat with r_last).
REQ-023 r_resp = 2'b10 SLVERR when burst==3, size > log2(NB), or WRAP with len not in {1,3,7,15}; such bursts still return len+1 beats with r_data 0 and no mem_ren; else 2'b00.
REQ-024 SRAM data and payload enter a 2-entry output skid FIFO; r_valid = FIFO non-empty; pop on r_valid & r_ready.
REQ-025 r_id/r_data/r_resp/r_last held stable while r_valid & ~r_ready.
REQ-026 Latency: AR accepted at cycle T from idle, r_ready high -> mem_ren at T+2, first r_valid at T+3, one beat per cycle thereafter.
REQ-027 r_ready low never drops or duplicates beats; throughput resumes the cycle r_ready returns.
REQ-028 Push and pop of AR queue in the same cycle when full is not allowed (ar_ready low); same-cycle push/pop when not full is allowed.

Reset
REQ-029 While rst = 0: ar_ready, r_valid, r_last, mem_ren = 0; r_resp, r_id, r_data = 0; FSM IDLE; queues empty; counters 0.
REQ-030 Reset mid-burst abandons all queued, in-flight and buffered beats; first cycle after release ar_ready = 1, r_valid = 0.

Structure
REQ-031 Burst encodings, resp codes (OKAY, SLVERR) and the AR entry struct live in the shared defines package.
REQ-032 One sub-module, axi_resp_fifo (2-entry parameterised-width FIFO), instantiated for the AR queue and the skid buffer.

Verification
REQ-033 INCR addr 0x80000040, len 7, size 3, id 2, r_ready=1 -> mem_raddr 0x40..0x78 step 8, 8 beats id 2, r_last only on beat 7, first r_valid T+3.
REQ-034 WRAP addr 0x38, len 3, size 3 -> mem_raddr 0x38, 0x20, 0x28, 0x30.
REQ-035 burst=3, len 1 -> 2 beats r_resp 2'b10, data 0, mem_ren never asserted.
REQ-036 Two ARs back-to-back plus a third -> ar_ready drops after second accept; data in order, no gap >1 cycle between bursts.
REQ-037 r_ready toggled randomly (50%) on len 15 INCR -> all 16 beats in order, payload stable while stalled.
REQ-038 rst low at beat 3 of len 7 -> outputs zero immediately; after release new len 0 AR returns one beat with r_last.

Source files
------------

// File: rtl/axi_read_responder_pkg.sv
// Shared encodings for the AXI read responder: burst types, response codes,
// the queued AR control fields and the burst legality check.
`ifndef PADDR_SIZE
`define PADDR_SIZE 32
`endif
`ifndef XLEN
`define XLEN 64
`endif

package axi_read_responder_pkg;

  typedef enum logic [1:0] {
    BURST_FIXED = 2'd0,
    BURST_INCR  = 2'd1,
    BURST_WRAP  = 2'd2,
    BURST_RSVD  = 2'd3
  } burst_e;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  typedef struct packed {
    logic [7:0] len;
    logic [2:0] size;
    burst_e     burst;
  } ar_ctrl_t;

  // A bad burst still returns len+1 beats, but with SLVERR and no SRAM reads.
  function automatic logic burst_is_bad(input ar_ctrl_t c, input int nb_log2);
    logic wrap_len_ok;
    wrap_len_ok = (c.len == 8'd1) || (c.len == 8'd3) || (c.len == 8'd7) || (c.len == 8'd15);
    return (c.burst == BURST_RSVD) || (int'(c.size) > nb_log2) ||
           ((c.burst == BURST_WRAP) && !wrap_len_ok);
  endfunction

endpackage

// File: rtl/axi_resp_fifo.sv
// Two-entry FIFO of arbitrary width; head is valid whenever count is non-zero.
module axi_resp_fifo #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] head,
  output logic [1:0]       count
);

  logic [WIDTH-1:0] mem [2];
  logic             wr_ptr;
  logic             rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign do_push = push && (count != 2'd2);
  assign do_pop  = pop && (count != 2'd0);
  assign head    = mem[rd_ptr];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      count  <= 2'd0;
    end else begin
      if (do_push) wr_ptr <= ~wr_ptr;
      if (do_pop)  rd_ptr <= ~rd_ptr;
      case ({do_push, do_pop})
        2'b10:   count <= count + 2'd1;
        2'b01:   count <= count - 2'd1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

endmodule

// File: rtl/axi_read_responder.sv
// AXI read-channel responder: queues AR requests, walks each burst against a
// one-cycle-latency SRAM and returns beats through a fall-through skid FIFO.
`ifndef PADDR_SIZE
`define PADDR_SIZE 32
`endif
`ifndef XLEN
`define XLEN 64
`endif

module axi_read_responder
  import axi_read_responder_pkg::*;
#(
  parameter int ADDR_W = `PADDR_SIZE,
  parameter int DATA_W = `XLEN,
  parameter int ID_W   = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              ar_valid,
  output logic              ar_ready,
  input  logic [ID_W-1:0]   ar_id,
  input  logic [ADDR_W-1:0] ar_addr,
  input  logic [7:0]        ar_len,
  input  logic [2:0]        ar_size,
  input  logic [1:0]        ar_burst,
  output logic              r_valid,
  input  logic              r_ready,
  output logic [ID_W-1:0]   r_id,
  output logic [DATA_W-1:0] r_data,
  output logic [1:0]        r_resp,
  output logic              r_last,
  output logic              mem_ren,
  output logic [ADDR_W-1:0] mem_raddr,
  input  logic [DATA_W-1:0] mem_rdata
);

  localparam int NB      = DATA_W / 8;
  localparam int NB_LOG2 = $clog2(NB);
  localparam int AR_W    = ID_W + ADDR_W + $bits(ar_ctrl_t);
  localparam int R_W     = ID_W + DATA_W + 3;

  typedef enum logic {ST_IDLE, ST_BURST} state_e;

  function automatic logic [ADDR_W-1:0] next_addr(input logic [ADDR_W-1:0] a, input ar_ctrl_t c);
    logic [ADDR_W-1:0] step;
    logic [ADDR_W-1:0] mask;
    step = ADDR_W'(1) << c.size;
    mask = ((ADDR_W'(c.len) + ADDR_W'(1)) << c.size) - ADDR_W'(1);
    case (c.burst)
      BURST_INCR: return a + step;
      BURST_WRAP: return (a & ~mask) | ((a + step) & mask);
      default:    return a;
    endcase
  endfunction

  // AR queue
  ar_ctrl_t          ar_ctrl_in;
  logic [AR_W-1:0]   ar_head;
  logic [1:0]        ar_count;
  logic              ar_push;
  logic              ar_pop;
  logic [ID_W-1:0]   hd_id;
  logic [ADDR_W-1:0] hd_addr;
  ar_ctrl_t          hd_ctrl;

  assign ar_ready   = rst && (ar_count != 2'd2);
  assign ar_push    = ar_valid && ar_ready;
  assign ar_ctrl_in = '{len: ar_len, size: ar_size, burst: burst_e'(ar_burst)};
  assign {hd_id, hd_addr, hd_ctrl} = ar_head;

  axi_resp_fifo #(.WIDTH(AR_W)) u_ar_q (
    .clk       (clk),
    .rst       (rst),
    .push      (ar_push),
    .push_data ({ar_id, ar_addr, ar_ctrl_in}),
    .pop       (ar_pop),
    .head      (ar_head),
    .count     (ar_count)
  );

  // Stage p0: burst context and beat issue
  state_e            state_q;
  state_e            state_d;
  logic [7:0]        beat_p0;
  logic [ADDR_W-1:0] addr_p0;
  logic [ID_W-1:0]   id_p0;
  ar_ctrl_t          ctrl_p0;
  logic              err_p0;
  logic              issue;
  logic              room;

  // Stage p1: SRAM data returning, then skid FIFO
  logic              vld_p1;
  logic              last_p1;
  logic              err_p1;
  logic [ID_W-1:0]   id_p1;
  logic [DATA_W-1:0] data_in;
  logic [1:0]        resp_in;
  logic [R_W-1:0]    beat_in;
  logic [R_W-1:0]    skid_head;
  logic [R_W-1:0]    r_bus;
  logic [1:0]        skid_count;
  logic              skid_push;
  logic              skid_pop;
  logic              deliver;
  logic [2:0]        pending;

  always_comb begin
    state_d = state_q;
    ar_pop  = 1'b0;
    issue   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (ar_count != 2'd0) begin
          ar_pop  = 1'b1;
          state_d = ST_BURST;
        end
      end
      ST_BURST: begin
        if (room) begin
          issue = 1'b1;
          if (beat_p0 == ctrl_p0.len) state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign mem_ren   = issue && !err_p0;
  assign mem_raddr = addr_p0 & ~ADDR_W'(NB - 1);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= ST_IDLE;
      beat_p0 <= 8'd0;
      vld_p1  <= 1'b0;
    end else begin
      state_q <= state_d;
      vld_p1  <= issue;
      if (ar_pop)     beat_p0 <= 8'd0;
      else if (issue) beat_p0 <= beat_p0 + 8'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (ar_pop) begin
      addr_p0 <= hd_addr;
      id_p0   <= hd_id;
      ctrl_p0 <= hd_ctrl;
      err_p0  <= burst_is_bad(hd_ctrl, NB_LOG2);
    end else if (issue) begin
      addr_p0 <= next_addr(addr_p0, ctrl_p0);
    end
    if (issue) begin
      id_p1   <= id_p0;
      last_p1 <= (beat_p0 == ctrl_p0.len);
      err_p1  <= err_p0;
    end
  end

  // Beats pass straight through when the skid is empty and the initiator is
  // ready; otherwise they park in the skid. Issue only when every outstanding
  // beat is guaranteed a skid slot.
  assign data_in   = err_p1 ? '0 : mem_rdata;
  assign resp_in   = err_p1 ? RESP_SLVERR : RESP_OKAY;
  assign beat_in   = {id_p1, data_in, resp_in, last_p1};
  assign r_valid   = (skid_count != 2'd0) || vld_p1;
  assign deliver   = r_valid && r_ready;
  assign skid_pop  = (skid_count != 2'd0) && r_ready;
  assign skid_push = vld_p1 && !((skid_count == 2'd0) && r_ready);
  assign pending   = {1'b0, skid_count} + {2'b00, vld_p1} - {2'b00, deliver};
  assign room      = (pending < 3'd2);

  axi_resp_fifo #(.WIDTH(R_W)) u_skid (
    .clk       (clk),
    .rst       (rst),
    .push      (skid_push),
    .push_data (beat_in),
    .pop       (skid_pop),
    .head      (skid_head),
    .count     (skid_count)
  );

  always_comb begin
    r_bus = '0;
    if (skid_count != 2'd0) r_bus = skid_head;
    else if (vld_p1)        r_bus = beat_in;
  end

  assign {r_id, r_data, r_resp, r_last} = r_bus;

endmodule

// File: tb/tb_axi_read_responder.sv
// Directed bench for axi_read_responder: a burst-level reference model checked
// every cycle, plus literal expectations for addresses, latency and responses.
module tb_axi_read_responder;

  localparam int ADDR_W = 32;
  localparam int DATA_W = 64;
  localparam int ID_W   = 4;

  logic              clk = 1'b0;
  logic              rst = 1'b0;
  logic              ar_valid = 1'b0;
  logic              ar_ready;
  logic [ID_W-1:0]   ar_id = '0;
  logic [ADDR_W-1:0] ar_addr = '0;
  logic [7:0]        ar_len = '0;
  logic [2:0]        ar_size = '0;
  logic [1:0]        ar_burst = '0;
  logic              r_valid;
  logic              r_ready = 1'b1;
  logic [ID_W-1:0]   r_id;
  logic [DATA_W-1:0] r_data;
  logic [1:0]        r_resp;
  logic              r_last;
  logic              mem_ren;
  logic [ADDR_W-1:0] mem_raddr;
  logic [DATA_W-1:0] mem_rdata = '0;

  axi_read_responder #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .ID_W(ID_W)) dut (
    .clk(clk), .rst(rst),
    .ar_valid(ar_valid), .ar_ready(ar_ready), .ar_id(ar_id), .ar_addr(ar_addr),
    .ar_len(ar_len), .ar_size(ar_size), .ar_burst(ar_burst),
    .r_valid(r_valid), .r_ready(r_ready), .r_id(r_id), .r_data(r_data),
    .r_resp(r_resp), .r_last(r_last),
    .mem_ren(mem_ren), .mem_raddr(mem_raddr), .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [63:0] memf(input logic [31:0] a);
    return {a ^ 32'hC0DE_0000, a + 32'h0000_0011};
  endfunction

  // SRAM: data one cycle after the read strobe, junk otherwise
  always @(posedge clk) mem_rdata <= mem_ren ? memf(mem_raddr) : 64'hBAD0_BAD0_BAD0_BAD0;

  typedef struct packed {
    logic [3:0]  id;
    logic [63:0] data;
    logic [1:0]  resp;
    logic        last;
  } beat_t;

  beat_t       exp_beat[$];
  logic [31:0] exp_addr[$];
  logic [31:0] ren_log[$];
  int          ren_cyc[$];
  int          dl_cyc[$];
  bit          dl_last[$];
  beat_t       dl_word[$];
  int          n_tests = 0;
  int          n_fail  = 0;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Expand one accepted AR into its SRAM addresses and response beats.
  task automatic model_accept(input logic [3:0] id, input logic [31:0] addr, input logic [7:0] len,
                              input logic [2:0] size, input logic [1:0] burst);
    longint nbytes, wsize, base, a0, a, aa;
    bit     bad;
    beat_t  b;
    bad    = (burst == 2'd3) || (size > 3'd3) ||
             ((burst == 2'd2) && !(len == 8'd1 || len == 8'd3 || len == 8'd7 || len == 8'd15));
    a0     = longint'(addr);
    nbytes = longint'(1) << size;
    wsize  = (longint'(len) + 1) * nbytes;
    base   = a0 - (a0 % wsize);
    for (int i = 0; i <= int'(len); i++) begin
      case (burst)
        2'd1:    a = a0 + i * nbytes;
        2'd2:    a = base + (((a0 - base) + i * nbytes) % wsize);
        default: a = a0;
      endcase
      aa = (a - (a % 8)) & 64'hFFFF_FFFF;
      if (!bad) exp_addr.push_back(aa[31:0]);
      b.id   = id;
      b.data = bad ? 64'd0 : memf(aa[31:0]);
      b.resp = bad ? 2'b10 : 2'b00;
      b.last = (i == int'(len));
      exp_beat.push_back(b);
    end
  endtask

  beat_t held;
  bit    hold_q = 0;

  always @(negedge clk) begin
    beat_t act;
    act = '{id: r_id, data: r_data, resp: r_resp, last: r_last};
    if (!rst) begin
      check("reset_outputs", {ar_ready, r_valid, r_last, mem_ren, r_resp, r_id, r_data}, 0);
      exp_beat.delete();
      exp_addr.delete();
      hold_q = 0;
    end else begin
      if (hold_q) begin
        check("stall_valid", r_valid, 1);
        check("stall_payload", act, held);
      end
      hold_q = r_valid && !r_ready;
      held   = act;
      if (ar_valid && ar_ready) model_accept(ar_id, ar_addr, ar_len, ar_size, ar_burst);
      if (mem_ren) begin
        ren_log.push_back(mem_raddr);
        ren_cyc.push_back(cyc);
        if (exp_addr.size() == 0) check("mem_ren_unexpected", mem_ren, 0);
        else                      check("mem_raddr", mem_raddr, exp_addr.pop_front());
      end
      if (r_valid && r_ready) begin
        dl_cyc.push_back(cyc);
        dl_last.push_back(r_last);
        dl_word.push_back(act);
        if (exp_beat.size() == 0) check("r_beat_unexpected", r_valid, 0);
        else                      check("r_beat", act, exp_beat.pop_front());
      end
    end
  end

  task automatic clear_logs();
    ren_log.delete(); ren_cyc.delete(); dl_cyc.delete(); dl_last.delete(); dl_word.delete();
  endtask

  task automatic send_ar(input logic [3:0] id, input logic [31:0] addr, input logic [7:0] len,
                         input logic [2:0] size, input logic [1:0] burst, output int t);
    bit ok;
    ok = 0;
    t  = -1;
    ar_id = id; ar_addr = addr; ar_len = len; ar_size = size; ar_burst = burst;
    ar_valid = 1'b1;
    for (int k = 0; k < 100 && !ok; k++) begin
      @(negedge clk);
      if (ar_ready) begin ok = 1; t = cyc; end
    end
    if (!ok) check("ar_accept_timeout", ar_ready, 1);
    @(posedge clk); #1;
    ar_valid = 1'b0;
  endtask

  task automatic wait_idle();
    bit done;
    done = 0;
    for (int k = 0; k < 500 && !done; k++) begin
      @(negedge clk);
      if (exp_beat.size() == 0) done = 1;
    end
    check("drain_timeout", done, 1);
    repeat (3) @(negedge clk);
    check("ren_leftover", exp_addr.size(), 0);
    @(posedge clk); #1;
  endtask

  initial begin
    #500_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int t, t1, t2, t3, t4, maxgap, nlast;
    logic [31:0] wexp [4];
    wexp[0] = 32'h38; wexp[1] = 32'h20; wexp[2] = 32'h28; wexp[3] = 32'h30;

    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_ar_ready", ar_ready, 0);
    check("rst_r_valid", r_valid, 0);
    @(posedge clk); #1;
    rst = 1'b1;
    @(negedge clk);
    check("post_rst_ar_ready", ar_ready, 1);
    check("post_rst_r_valid", r_valid, 0);
    @(posedge clk); #1;

    clear_logs();
    send_ar(4'd2, 32'h8000_0040, 8'd7, 3'd3, 2'd1, t);
    wait_idle();
    check("incr_beats", dl_cyc.size(), 8);
    check("incr_ren_latency", ren_cyc.size() > 0 ? ren_cyc[0] : -1, t + 2);
    check("incr_rvalid_latency", dl_cyc.size() > 0 ? dl_cyc[0] : -1, t + 3);
    check("incr_first_addr", ren_log.size() > 0 ? ren_log[0] : 0, 32'h8000_0040);
    check("incr_last_addr", ren_log.size() > 7 ? ren_log[7] : 0, 32'h8000_0078);
    check("incr_first_id", dl_word.size() > 0 ? dl_word[0].id : 4'hF, 4'd2);
    nlast = 0;
    foreach (dl_last[i]) nlast += int'(dl_last[i]);
    check("incr_last_count", nlast, 1);
    check("incr_last_on_7", dl_last.size() > 7 ? dl_last[7] : 1'b0, 1);

    clear_logs();
    send_ar(4'd5, 32'h38, 8'd3, 3'd3, 2'd2, t);
    wait_idle();
    check("wrap_ren_count", ren_log.size(), 4);
    for (int i = 0; i < 4; i++) check("wrap_addr", ren_log.size() > i ? ren_log[i] : 0, wexp[i]);

    clear_logs();
    send_ar(4'd7, 32'h1000, 8'd1, 3'd3, 2'd3, t);
    wait_idle();
    check("rsvd_ren_count", ren_log.size(), 0);
    check("rsvd_beats", dl_word.size(), 2);
    check("rsvd_resp", dl_word.size() > 0 ? dl_word[0].resp : 2'b00, 2'b10);
    check("rsvd_data", dl_word.size() > 1 ? dl_word[1].data : 64'hFF, 64'd0);

    clear_logs();
    send_ar(4'd3, 32'h104, 8'd2, 3'd2, 2'd0, t);
    wait_idle();
    check("fixed_ren_count", ren_log.size(), 3);
    check("fixed_addr", ren_log.size() > 2 ? ren_log[2] : 0, 32'h100);

    clear_logs();
    send_ar(4'd8, 32'h200, 8'd2, 3'd3, 2'd2, t);
    send_ar(4'd9, 32'h300, 8'd0, 3'd4, 2'd1, t);
    wait_idle();
    check("badwrap_bigsize_ren", ren_log.size(), 0);
    check("badwrap_bigsize_beats", dl_word.size(), 4);
    check("bigsize_resp", dl_word.size() > 3 ? dl_word[3].resp : 2'b00, 2'b10);

    clear_logs();
    send_ar(4'd1, 32'h1000, 8'd3, 3'd3, 2'd1, t1);
    send_ar(4'd2, 32'h2000, 8'd1, 3'd3, 2'd1, t2);
    send_ar(4'd3, 32'h3000, 8'd0, 3'd3, 2'd1, t3);
    @(negedge clk);
    check("queue_full_ar_ready", ar_ready, 0);
    @(posedge clk); #1;
    send_ar(4'd4, 32'h4000, 8'd2, 3'd3, 2'd1, t4);
    wait_idle();
    check("b2b_beats", dl_cyc.size(), 10);
    maxgap = 0;
    for (int i = 1; i < dl_cyc.size(); i++)
      if (dl_cyc[i] - dl_cyc[i-1] > maxgap) maxgap = dl_cyc[i] - dl_cyc[i-1];
    check("b2b_gap_le2", maxgap <= 2, 1);
    check("b2b_last_id", dl_word.size() > 9 ? dl_word[9].id : 4'h0, 4'd4);

    clear_logs();
    send_ar(4'd9, 32'h2000, 8'd15, 3'd3, 2'd1, t);
    for (int k = 0; k < 400; k++) begin
      @(posedge clk); #1;
      r_ready = 1'($urandom_range(0, 1));
      if (exp_beat.size() == 0) break;
    end
    r_ready = 1'b1;
    wait_idle();
    check("stall_beats", dl_cyc.size(), 16);
    check("stall_last_addr", ren_log.size() > 15 ? ren_log[15] : 0, 32'h2078);

    clear_logs();
    send_ar(4'd4, 32'h3000, 8'd7, 3'd3, 2'd1, t);
    for (int k = 0; k < 50; k++) begin
      @(negedge clk);
      if (dl_cyc.size() >= 3) break;
    end
    check("midrst_reached_beat3", dl_cyc.size() >= 3, 1);
    @(posedge clk); #1;
    rst = 1'b0;
    #1;
    check("midrst_outputs", {r_valid, mem_ren, ar_ready, r_last, r_resp, r_id, r_data}, 0);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1;
    @(negedge clk);
    check("midrst_release_ar_ready", ar_ready, 1);
    check("midrst_release_r_valid", r_valid, 0);
    @(posedge clk); #1;
    clear_logs();
    send_ar(4'd6, 32'h4000, 8'd0, 3'd3, 2'd1, t);
    wait_idle();
    check("post_rst_beats", dl_cyc.size(), 1);
    check("post_rst_last", dl_last.size() > 0 ? dl_last[0] : 1'b0, 1);
    check("post_rst_id", dl_word.size() > 0 ? dl_word[0].id : 4'h0, 4'd6);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
